// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor, one decimal digit per clock, LSD first.
// Optional macro BCD_SIGNMAG_EN adds a FIX pass that turns negative results into magnitude form.
module bcd_addsub_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  m,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  carry,
    output logic                  neg,
    output logic                  err
);
    localparam int W  = 4 * DIGITS;
    localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // IDLE wait operands | RUN one digit per cycle | FIX 10's complement of sum | DONE hold result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
`ifdef BCD_SIGNMAG_EN
        FIX  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            m_q, m_d, c_q, c_d;
    logic            carry_q, carry_d, neg_q, neg_d, err_q, err_d;
    logic            out_valid_q, out_valid_d;

    logic [W-1:0]    a_sh, b_sh, s_sh, dmask, dval;
    logic [3:0]      a_dig, b_dig, s_dig, op1, op2, digit;
    logic [4:0]      t;
    logic            ge10, last;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction

    assign a_sh  = a_q >> {k_q, 2'b00};
    assign b_sh  = b_q >> {k_q, 2'b00};
    assign s_sh  = sum_q >> {k_q, 2'b00};
    assign a_dig = a_sh[3:0];
    assign b_dig = b_sh[3:0];
    assign s_dig = s_sh[3:0];
    assign last  = (k_q == KW'(DIGITS - 1));

    always_comb begin
        op1 = a_dig;
        op2 = m_q ? 4'(4'd9 - b_dig) : b_dig;
`ifdef BCD_SIGNMAG_EN
        if (state_q == FIX) begin
            op1 = 4'(4'd9 - s_dig);
            op2 = 4'd0;
        end
`endif
    end

    assign t     = 5'(op1) + 5'(op2) + 5'(c_q);
    assign ge10  = (t >= 5'd10);
    assign digit = ge10 ? 4'(t - 5'd10) : t[3:0];
    assign dmask = ~(W'(4'hF) << {k_q, 2'b00});
    assign dval  = W'(digit) << {k_q, 2'b00};

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        m_d         = m_q;
        c_d         = c_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        neg_d       = neg_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    m_d     = m;
                    k_d     = '0;
                    c_d     = m;
                    err_d   = has_bad_digit(a) | has_bad_digit(b);
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d = (sum_q & dmask) | dval;
                c_d   = ge10;
                if (last) begin
                    carry_d = ge10;
                    neg_d   = m_q & ~ge10;
                    state_d = DONE;
`ifdef BCD_SIGNMAG_EN
                    if (m_q && !ge10) begin
                        state_d = FIX;
                        k_d     = '0;
                        c_d     = 1'b1;
                    end
`endif
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
`ifdef BCD_SIGNMAG_EN
            FIX: begin
                sum_d = (sum_q & dmask) | dval;
                c_d   = ge10;
                if (last) state_d = DONE;
                else      k_d = k_q + 1'b1;
            end
`endif
            DONE: begin
                // Result registers settle one cycle before out_valid is raised.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            m_q         <= 1'b0;
            c_q         <= 1'b0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            m_q         <= m_d;
            c_q         <= c_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            neg_q       <= neg_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign neg       = neg_q;
    assign err       = err_q;
endmodule
